mdu_ctrl: RTL and testbench

- Multi-cycle multiply/divide controller for the 5-stage pipeline, sitting in the E stage beside the ALU.
- Accepts mult/multu/div/divu/mthi/mtlo issued from E and sequences a fixed-latency operation.
- Owns the HI/LO registers and supplies them to mfhi/mflo.
- Generates the stall request that freezes PC/D_REG and bubbles E_REG while any D-stage MDU instruction must wait.

---
 rtl/mdu_ctrl_pkg.sv | 28 ++
 rtl/mdu_core.sv | 46 ++++
 rtl/mdu_ctrl.sv | 114 +++++++++++
 tb/tb_mdu_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mdu_ctrl_pkg.sv
// Shared MDU definitions: op encodings (also used by the decoder), default latencies, result payload.
package mdu_ctrl_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned OP_W   = 3;

  localparam logic [OP_W-1:0] MDU_MULT  = 3'd0;
  localparam logic [OP_W-1:0] MDU_MULTU = 3'd1;
  localparam logic [OP_W-1:0] MDU_DIV   = 3'd2;
  localparam logic [OP_W-1:0] MDU_DIVU  = 3'd3;
  localparam logic [OP_W-1:0] MDU_MTHI  = 3'd4;
  localparam logic [OP_W-1:0] MDU_MTLO  = 3'd5;

  localparam int unsigned MDU_MULT_CYCLES_DEF = 5;
  localparam int unsigned MDU_DIV_CYCLES_DEF  = 10;

  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic            div0;
  } mdu_res_t;

  // Ops that occupy the unit for multiple cycles.
  function automatic logic is_long_op(input logic [OP_W-1:0] op);
    return op <= MDU_DIVU;
  endfunction

endpackage

// File: rtl/mdu_core.sv
// Combinational MDU datapath: 32x32 signed/unsigned multiply and divide/remainder.
module mdu_core
  import mdu_ctrl_pkg::*;
(
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output mdu_res_t        res
);

  logic signed [63:0]     smul;
  logic        [63:0]     umul;
  logic                   s_ovf;
  logic        [XLEN-1:0] bd_s;
  logic        [XLEN-1:0] bd_u;
  logic signed [XLEN-1:0] sq;
  logic signed [XLEN-1:0] sr;
  logic        [XLEN-1:0] uq;
  logic        [XLEN-1:0] ur;

  // Divisors are forced to 1 for /0 and INT_MIN/-1 so the operators stay defined;
  // INT_MIN/1 yields the wrapped quotient 0x80000000 with remainder 0.
  always_comb begin
    smul  = $signed({{XLEN{a[XLEN-1]}}, a}) * $signed({{XLEN{b[XLEN-1]}}, b});
    umul  = {32'd0, a} * {32'd0, b};
    s_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    bd_s  = ((b == '0) || s_ovf) ? 32'd1 : b;
    bd_u  = (b == '0) ? 32'd1 : b;
    sq    = $signed(a) / $signed(bd_s);
    sr    = $signed(a) % $signed(bd_s);
    uq    = a / bd_u;
    ur    = a % bd_u;
  end

  always_comb begin
    res = '0;
    case (op)
      MDU_MULT:  begin res.hi = smul[63:32]; res.lo = smul[31:0]; end
      MDU_MULTU: begin res.hi = umul[63:32]; res.lo = umul[31:0]; end
      MDU_DIV:   begin res.hi = sr; res.lo = sq; res.div0 = (b == '0); end
      MDU_DIVU:  begin res.hi = ur; res.lo = uq; res.div0 = (b == '0); end
      default:   res = '0;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide controller: fixed-latency sequencing, HI/LO ownership, D-stage stall.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            E_mdu_start,
  input  logic [OP_W-1:0] E_mdu_op,
  input  logic [XLEN-1:0] E_A,
  input  logic [XLEN-1:0] E_B,
  input  logic            D_mdu_use,
  output logic            busy,
  output logic            stall,
  output logic [XLEN-1:0] HI,
  output logic [XLEN-1:0] LO
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] pend_hi_q, pend_hi_d;
  logic [XLEN-1:0] pend_lo_q, pend_lo_d;
  logic            div0_q, div0_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  mdu_res_t        core_res;

  mdu_core u_core (
    .op  (E_mdu_op),
    .a   (E_A),
    .b   (E_B),
    .res (core_res)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      IDLE: begin
        if (E_mdu_start) begin
          case (E_mdu_op)
            MDU_MULT, MDU_MULTU: begin
              pend_hi_d = core_res.hi;
              pend_lo_d = core_res.lo;
              div0_d    = 1'b0;
              cnt_d     = CNT_W'(MULT_CYCLES);
              state_d   = RUN;
            end
            MDU_DIV, MDU_DIVU: begin
              pend_hi_d = core_res.hi;
              pend_lo_d = core_res.lo;
              div0_d    = core_res.div0;
              cnt_d     = CNT_W'(DIV_CYCLES);
              state_d   = RUN;
            end
            MDU_MTHI: hi_d = E_A;
            MDU_MTLO: lo_d = E_A;
            default:  ;
          endcase
        end
      end
      RUN: begin
        // New starts are ignored here; the final decrement commits unless /0 was seen.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          if (!div0_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy  = (state_q == RUN);
  assign HI    = hi_q;
  assign LO    = lo_q;
  assign stall = D_mdu_use & (busy | (E_mdu_start & is_long_op(E_mdu_op)));

endmodule

// File: tb/tb_mdu_ctrl.sv
// Randomized + directed bench for mdu_ctrl against a cycle-level behavioural model.
module tb_mdu_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        reset;
  logic        E_mdu_start;
  logic [2:0]  E_mdu_op;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        D_mdu_use;
  logic        busy;
  logic        stall;
  logic [31:0] HI;
  logic [31:0] LO;

  int total = 0;
  int bad   = 0;

  int          m_left;
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  bit          m_div0;

  mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk         (clk),
    .reset       (reset),
    .E_mdu_start (E_mdu_start),
    .E_mdu_op    (E_mdu_op),
    .E_A         (E_A),
    .E_B         (E_B),
    .D_mdu_use   (D_mdu_use),
    .busy        (busy),
    .stall       (stall),
    .HI          (HI),
    .LO          (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference result {hi, lo} from 64-bit integer arithmetic.
  function automatic logic [63:0] ref_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sp, q, r;
    longint unsigned ua, ub, up, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    case (op)
      3'd0: begin sp = sa * sb; return 64'(sp); end
      3'd1: begin up = ua * ub; return up; end
      3'd2: begin
        if (b == 0) return 64'd0;
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 0) return 64'd0;
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      default: return 64'd0;
    endcase
  endfunction

  // One clock: check registered outputs, drive inputs, check stall, advance model.
  task automatic cyc(input logic r, input logic s, input logic [2:0] op,
                     input logic [31:0] a, input logic [31:0] b, input logic du);
    logic exp_stall;
    @(negedge clk);
    chk("busy", 32'(busy), 32'(m_left != 0));
    chk("hi", HI, m_hi);
    chk("lo", LO, m_lo);
    reset = r; E_mdu_start = s; E_mdu_op = op; E_A = a; E_B = b; D_mdu_use = du;
    #1;
    exp_stall = du & ((m_left != 0) | (s & (op <= 3'd3)));
    chk("stall", 32'(stall), 32'(exp_stall));
    @(posedge clk);
    if (r) begin
      m_left = 0; m_hi = '0; m_lo = '0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && !m_div0) begin
        m_hi = m_phi; m_lo = m_plo;
      end
    end else if (s) begin
      case (op)
        3'd0, 3'd1: begin {m_phi, m_plo} = ref_calc(op, a, b); m_div0 = 1'b0; m_left = MULT_N; end
        3'd2, 3'd3: begin {m_phi, m_plo} = ref_calc(op, a, b); m_div0 = (b == 0); m_left = DIV_N; end
        3'd4: m_hi = a;
        3'd5: m_lo = a;
        default: ;
      endcase
    end
  endtask

  task automatic idle(input logic du);
    cyc(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, du);
  endtask

  // Issue an op and count the busy cycles that follow; optionally poke a start mid-flight.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic du, input logic poke, output int nb);
    nb = 0;
    cyc(1'b0, 1'b1, op, a, b, du);
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!busy) break;
      nb++;
      cyc(1'b0, poke && (i == 2), 3'd3, 32'd9, 32'd4, du);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int nb;
    reset = 1'b1; E_mdu_start = 1'b0; E_mdu_op = 3'd0; E_A = '0; E_B = '0; D_mdu_use = 1'b0;
    m_left = 0; m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0; m_div0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);

    // Reset while a divide is at counter 3 aborts without commit.
    cyc(1'b0, 1'b1, 3'd2, 32'd100, 32'd7, 1'b0);
    repeat (7) idle(1'b0);
    cyc(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);
    repeat (12) idle(1'b0);
    #1;
    chk("abort_late_lo", LO, 32'd0);

    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0, nb);
    chk("mult_n", 32'(nb), 32'd5);
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFFA);
    idle(1'b1);

    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b1, nb);
    chk("multu_n", 32'(nb), 32'd5);
    chk("multu_hi", HI, 32'h0000_0002);
    chk("multu_lo", LO, 32'hFFFF_FFFA);

    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, nb);
    chk("div_n", 32'(nb), 32'd10);
    chk("div_hi", HI, 32'hFFFF_FFFF);
    chk("div_lo", LO, 32'hFFFF_FFFD);

    run_op(3'd3, 32'd7, 32'd2, 1'b0, 1'b0, nb);
    chk("divu_n", 32'(nb), 32'd10);
    chk("divu_hi", HI, 32'd1);
    chk("divu_lo", LO, 32'd3);

    cyc(1'b0, 1'b1, 3'd4, 32'h11, 32'd0, 1'b1);
    cyc(1'b0, 1'b1, 3'd5, 32'h22, 32'd0, 1'b0);
    run_op(3'd2, 32'd5, 32'd0, 1'b0, 1'b0, nb);
    chk("div0_n", 32'(nb), 32'd10);
    chk("div0_hi", HI, 32'h11);
    chk("div0_lo", LO, 32'h22);

    cyc(1'b0, 1'b1, 3'd5, 32'hDEAD_BEEF, 32'd0, 1'b0);
    #1;
    chk("mtlo_lo", LO, 32'hDEAD_BEEF);
    chk("mtlo_busy", 32'(busy), 32'd0);
    cyc(1'b0, 1'b1, 3'd6, 32'h1234_5678, 32'd1, 1'b1);
    #1;
    chk("rsvd_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 600; i++) begin
      logic r, s;
      r = ($urandom_range(0, 99) == 0);
      s = (m_left == 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      cyc(r, s, 3'($urandom_range(0, 7)), pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
    end
    idle(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
